// File: rtl/pipe_ctrl_pkg.sv
// Shared constants and state encoding for the pipeline sequencer.
package pipe_ctrl_pkg;

    localparam int unsigned STALL_W = 6;

    localparam logic [STALL_W-1:0] STALL_NONE = 6'b000000;
    localparam logic [STALL_W-1:0] STALL_ID   = 6'b000111;
    localparam logic [STALL_W-1:0] STALL_EX   = 6'b001111;

    typedef enum logic [1:0] {
        PC_RUN   = 2'd0,
        PC_MC    = 2'd1,
        PC_FLUSH = 2'd2
    } pc_state_e;

endpackage

// File: rtl/pipe_mc_timer.sv
// Loadable down-counter for multi-cycle EX ops, with zero flag and a registered done pulse.
module pipe_mc_timer #(
    parameter int unsigned LEN_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [LEN_W-1:0] len,
    input  logic             dec,
    input  logic             clr,
    output logic             zero,
    output logic             done
);

    logic [LEN_W-1:0] cnt;

    // done is raised on the edge where the count reaches zero, so it is
    // visible during the final (zero) cycle of the op.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt  <= '0;
            done <= 1'b0;
        end else if (clr) begin
            cnt  <= '0;
            done <= 1'b0;
        end else if (load) begin
            cnt  <= len - LEN_W'(1);
            done <= (len == LEN_W'(1));
        end else if (dec && (cnt != '0)) begin
            cnt  <= cnt - LEN_W'(1);
            done <= (cnt == LEN_W'(1));
        end else begin
            done <= 1'b0;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: merges load-use, multi-cycle and exception requests into
// per-stage stalls plus a one-cycle flush with redirect PC.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned MC_LEN_W = 6,
    parameter int unsigned PC_W     = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stallreq_id,
    input  logic                ex_mc_start,
    input  logic [MC_LEN_W-1:0] ex_mc_len,
    input  logic                excp_i,
    input  logic [PC_W-1:0]     excp_pc_i,
    output logic [STALL_W-1:0]  stall_o,
    output logic                flush_o,
    output logic [PC_W-1:0]     new_pc_o,
    output logic                mc_busy_o,
    output logic                mc_done_o
);

    pc_state_e            state, state_n;
    logic [STALL_W-1:0]   stall;
    logic                 load, dec, clr, capture, zero;

    pipe_mc_timer #(.LEN_W(MC_LEN_W)) u_timer (
        .clk  (clk),
        .rst  (rst),
        .load (load),
        .len  (ex_mc_len),
        .dec  (dec),
        .clr  (clr),
        .zero (zero),
        .done (mc_done_o)
    );

    always_comb begin
        state_n = state;
        stall   = STALL_NONE;
        load    = 1'b0;
        dec     = 1'b0;
        clr     = 1'b0;
        capture = 1'b0;
        case (state)
            PC_RUN: begin
                if (excp_i) begin
                    capture = 1'b1;
                    state_n = PC_FLUSH;
                end else if (ex_mc_start && (ex_mc_len != '0)) begin
                    stall   = STALL_EX | (stallreq_id ? STALL_ID : STALL_NONE);
                    load    = 1'b1;
                    state_n = PC_MC;
                end else begin
                    stall = stallreq_id ? STALL_ID : STALL_NONE;
                end
            end
            PC_MC: begin
                if (excp_i) begin
                    clr     = 1'b1;
                    capture = 1'b1;
                    state_n = PC_FLUSH;
                end else if (!zero) begin
                    stall = STALL_EX;
                    dec   = 1'b1;
                end else begin
                    stall   = stallreq_id ? STALL_ID : STALL_NONE;
                    state_n = PC_RUN;
                end
            end
            PC_FLUSH: begin
                if (excp_i) begin
                    capture = 1'b1;
                end else begin
                    state_n = PC_RUN;
                end
            end
            default: state_n = PC_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= PC_RUN;
            flush_o  <= 1'b0;
            new_pc_o <= '0;
        end else begin
            state   <= state_n;
            flush_o <= (state_n == PC_FLUSH);
            if (capture) begin
                new_pc_o <= excp_pc_i;
            end
        end
    end

    // Stall is combinational, so it must be masked explicitly while reset is held.
    assign stall_o   = rst ? stall : STALL_NONE;
    assign mc_busy_o = (state == PC_MC);

endmodule
